pipe_hazard_sched: RTL and testbench

- Central stall/flush scheduler for the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Merges three hazard sources into one set of pipeline-register enables and flushes:
  - EX-stage branch/jump redirect.
  - Load-use hazard detected in ID.
  - Multi-cycle MUL/DIV unit occupying EX.
- Sequences the MUL/DIV unit with a start/done handshake and a timeout.
- Sits beside the pipeline registers and drives their we/flush pins directly.

---
 rtl/pipe_hazard_if.sv | 19 +
 rtl/pipe_hazard_sched.sv | 77 +++++++
 tb/tb_pipe_hazard_sched.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: hazard inputs, pipeline enables/flushes, MUL/DIV handshake and perf counters of the scheduler.
interface pipe_hazard_if #(parameter int PERF_W = 32);
    logic [4:0]        IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
    logic [1:0]        ID_EX_WDSel;
    logic              ID_EX_md_op, EX_branch_taken, md_done;
    logic              PC_we, IF_ID_we, IF_ID_flush, ID_EX_we, ID_EX_flush, EX_MEM_flush;
    logic              md_start, md_busy, md_err;
    logic [PERF_W-1:0] perf_lu, perf_md, perf_br;
    modport master (
        output IF_ID_rs1, IF_ID_rs2, ID_EX_rd, ID_EX_WDSel, ID_EX_md_op, EX_branch_taken, md_done,
        input  PC_we, IF_ID_we, IF_ID_flush, ID_EX_we, ID_EX_flush, EX_MEM_flush,
        input  md_start, md_busy, md_err, perf_lu, perf_md, perf_br
    );
    modport slave (
        input  IF_ID_rs1, IF_ID_rs2, ID_EX_rd, ID_EX_WDSel, ID_EX_md_op, EX_branch_taken, md_done,
        output PC_we, IF_ID_we, IF_ID_flush, ID_EX_we, ID_EX_flush, EX_MEM_flush,
        output md_start, md_busy, md_err, perf_lu, perf_md, perf_br
    );
endinterface

// File: rtl/pipe_hazard_sched.sv
// pipe_hazard_sched: stall/flush scheduler merging MUL/DIV freeze, branch redirect and load-use hazards.
// Define PIPE_PERF_CNT_EN to build the saturating performance counters.
module pipe_hazard_sched #(
    parameter int MD_TIMEOUT = 64,
    parameter int TO_W       = 16,
    parameter int PERF_W     = 32
) (
    input logic         clk,
    input logic         rst,
    pipe_hazard_if.slave hz
);
    typedef enum logic [1:0] {IDLE, START, WAIT, RELEASE} state_t;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);
    state_t          state_q;
    logic [TO_W-1:0] cnt_q;
    logic            err_q;
    logic            md_frz, br_c, lu_c, lu_hit;
    assign md_frz = (state_q == IDLE && hz.ID_EX_md_op && !hz.EX_branch_taken)
                  || state_q == START || state_q == WAIT;
    assign br_c   = hz.EX_branch_taken && !md_frz;
    assign lu_hit = hz.ID_EX_WDSel == 2'b01 && hz.ID_EX_rd != 5'd0
                  && (hz.ID_EX_rd == hz.IF_ID_rs1 || hz.ID_EX_rd == hz.IF_ID_rs2);
    assign lu_c   = lu_hit && !md_frz && !hz.EX_branch_taken;
    assign hz.PC_we        = !md_frz && !lu_c;
    assign hz.IF_ID_we     = !md_frz && !lu_c;
    assign hz.IF_ID_flush  = br_c;
    assign hz.ID_EX_we     = !md_frz;
    assign hz.ID_EX_flush  = br_c || lu_c;
    assign hz.EX_MEM_flush = md_frz;
    assign hz.md_start     = state_q == START;
    assign hz.md_busy      = state_q == START || state_q == WAIT;
    assign hz.md_err       = err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (hz.ID_EX_md_op && !hz.EX_branch_taken) state_q <= START;
                START: begin
                    cnt_q   <= '0;
                    state_q <= hz.md_done ? RELEASE : WAIT;
                end
                WAIT: begin
                    if (hz.md_done) state_q <= RELEASE;
                    else if (cnt_q == TO_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= RELEASE;
                    end else cnt_q <= cnt_q + TO_W'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] lu_q, md_q, br_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lu_q <= '0;
            md_q <= '0;
            br_q <= '0;
        end else begin
            if (lu_c && !(&lu_q)) lu_q <= lu_q + PERF_W'(1);
            if (md_frz && !(&md_q)) md_q <= md_q + PERF_W'(1);
            if (br_c && !(&br_q)) br_q <= br_q + PERF_W'(1);
        end
    end
    assign hz.perf_lu = lu_q;
    assign hz.perf_md = md_q;
    assign hz.perf_br = br_q;
`else
    assign hz.perf_lu = {PERF_W{1'b0}};
    assign hz.perf_md = {PERF_W{1'b0}};
    assign hz.perf_br = {PERF_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipe_hazard_sched.sv
// tb_pipe_hazard_sched: directed checks of hazard priority, MUL/DIV sequencing, timeout and reset.
module tb_pipe_hazard_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;
    always #5 clk = ~clk;
    pipe_hazard_if #(.PERF_W(32)) hz ();
    pipe_hazard_sched #(.MD_TIMEOUT(4), .TO_W(16), .PERF_W(32)) dut (.clk(clk), .rst(rst), .hz(hz));
    // {PC_we, IF_ID_we, IF_ID_flush, ID_EX_we, ID_EX_flush, EX_MEM_flush, md_start, md_busy, md_err}
    localparam logic [8:0] DEF   = 9'b110100000;
    localparam logic [8:0] LU    = 9'b000110000;
    localparam logic [8:0] BR    = 9'b111110000;
    localparam logic [8:0] FRZ   = 9'b000001000;
    localparam logic [8:0] FRZ_S = 9'b000001110;
    localparam logic [8:0] FRZ_B = 9'b000001010;
    localparam logic [8:0] ERR   = 9'b000000001;
    function automatic logic [8:0] outs();
        return {hz.PC_we, hz.IF_ID_we, hz.IF_ID_flush, hz.ID_EX_we, hz.ID_EX_flush,
                hz.EX_MEM_flush, hz.md_start, hz.md_busy, hz.md_err};
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask
    task automatic chk_o(input string tag, input logic [8:0] exp);
        #1 chk(tag, 32'(outs()), 32'(exp));
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        hz.IF_ID_rs1 = 5'd0; hz.IF_ID_rs2 = 5'd0; hz.ID_EX_rd = 5'd0; hz.ID_EX_WDSel = 2'b00;
        hz.ID_EX_md_op = 1'b0; hz.EX_branch_taken = 1'b0; hz.md_done = 1'b0;
        chk_o("reset_outs", DEF);
        chk("reset_perf_md", hz.perf_md, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        // load-use via rs1, then rd = 0, then via rs2, then non-load
        hz.ID_EX_WDSel = 2'b01; hz.ID_EX_rd = 5'd5; hz.IF_ID_rs1 = 5'd5;
        chk_o("lu_rs1", LU);
        tick();
        hz.ID_EX_rd = 5'd0; hz.IF_ID_rs1 = 5'd0;
        chk_o("lu_rd0", DEF);
        tick();
        hz.ID_EX_rd = 5'd5; hz.IF_ID_rs2 = 5'd5;
        chk_o("lu_rs2", LU);
        tick();
        hz.ID_EX_WDSel = 2'b00;
        chk_o("no_load", DEF);
        tick();
        hz.ID_EX_WDSel = 2'b01; hz.EX_branch_taken = 1'b1;
        chk_o("br_beats_lu", BR);
        tick();
`ifdef PIPE_PERF_CNT_EN
        chk("perf_lu", hz.perf_lu, 32'd2);
        chk("perf_br", hz.perf_br, 32'd1);
`else
        chk("perf_lu_tied", hz.perf_lu, 32'd0);
        chk("perf_br_tied", hz.perf_br, 32'd0);
`endif
        hz.ID_EX_WDSel = 2'b00; hz.IF_ID_rs2 = 5'd0; hz.ID_EX_rd = 5'd0;
        hz.ID_EX_md_op = 1'b1;
        chk_o("md_ignored_on_br", BR);
        tick();
        hz.EX_branch_taken = 1'b0;
        hz.ID_EX_md_op = 1'b0;
        chk_o("idle_after_br", DEF);
        tick();
        // MUL with md_done in the third WAIT cycle
        hz.ID_EX_md_op = 1'b1;
        chk_o("md_detect", FRZ);
        tick();
        chk_o("md_start", FRZ_S);
        tick();
        chk_o("md_wait1", FRZ_B);
        tick();
        chk_o("md_wait2", FRZ_B);
        tick();
        hz.md_done = 1'b1;
        chk_o("md_wait3", FRZ_B);
        tick();
        hz.md_done = 1'b0;
        chk_o("md_release", DEF);
        tick();
        // back-to-back DIV stays in EX with md_op = 1
        chk_o("div_detect", FRZ);
        tick();
        hz.md_done = 1'b1;
        chk_o("div_start", FRZ_S);
        tick();
        hz.md_done = 1'b0;
        chk_o("div_release_from_start", DEF);
        tick();
        hz.ID_EX_md_op = 1'b0;
        hz.md_done = 1'b1;
        chk_o("idle_spurious_done", DEF);
        tick();
        hz.md_done = 1'b0;
        chk_o("idle_after_spurious", DEF);
        tick();
        // timeout: four WAIT cycles with no md_done, branch masked by freeze
        hz.ID_EX_md_op = 1'b1;
        tick();
        chk_o("to_start", FRZ_S);
        tick();
        hz.EX_branch_taken = 1'b1;
        chk_o("to_wait_br_masked", FRZ_B);
        tick();
        hz.EX_branch_taken = 1'b0;
        tick();
        tick();
        chk_o("to_wait4", FRZ_B);
        tick();
        chk_o("to_release", DEF | ERR);
        hz.ID_EX_md_op = 1'b0;
        tick();
        chk_o("to_idle_err", DEF | ERR);
        tick();
        chk_o("to_err_sticky", DEF | ERR);
        // reset during WAIT
        hz.ID_EX_md_op = 1'b1;
        tick();
        tick();
        tick();
        chk_o("rst_pre_wait", FRZ_B | ERR);
        hz.ID_EX_md_op = 1'b0;
        rst = 1'b1;
        chk_o("rst_async", DEF);
`ifdef PIPE_PERF_CNT_EN
        chk("rst_perf_md", hz.perf_md, 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();
        chk_o("post_rst_default", DEF);
        chk("post_rst_perf_md", hz.perf_md, 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
